// File: rtl/heat_column_sweep_ctrl.sv
// Per-column sweep controller for the heat-equation stencil: streams one column's M10K rows,
// builds the up/center/down window with left/right neighbours, and writes interior results back.
module heat_column_sweep_ctrl #(
  parameter int unsigned ROWS = 32,
  parameter int unsigned AW   = 8,
  parameter int unsigned DW   = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [15:0]   num_steps,
  input  logic [DW-1:0] alpha_delta,
  output logic          busy,
  output logic          done,
  output logic [15:0]   step_count,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] q_center,
  input  logic [DW-1:0] q_left,
  input  logic [DW-1:0] q_right,
  output logic [AW-1:0] wr_addr,
  output logic          we,
  output logic [DW-1:0] wr_data,
  output logic [DW-1:0] node_up,
  output logic [DW-1:0] node_center,
  output logic [DW-1:0] node_down,
  output logic [DW-1:0] node_left,
  output logic [DW-1:0] node_right,
  output logic [DW-1:0] mult_alpha_delta,
  input  logic [DW-1:0] new_center
);

  localparam int unsigned CW = $clog2(ROWS + 1);
  localparam int unsigned SW = 16;
  localparam logic [CW-1:0] LAST_C   = CW'(ROWS - 1);
  localparam logic [CW-1:0] FLUSH_C  = CW'(ROWS);
  localparam logic [CW-1:0] FIRST_WR = CW'(3);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_FLUSH, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] c_q, c_d;
  logic [SW-1:0] num_steps_q, num_steps_d;
  logic [SW-1:0] step_count_q, step_count_d;
  logic [DW-1:0] alpha_q, alpha_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          we_q, we_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] node_center_q, node_center_d;
  logic [DW-1:0] node_up_q, node_up_d;
  logic [DW-1:0] node_left_q, node_left_d;
  logic [DW-1:0] node_right_q, node_right_d;

  // Sequencing plus registered outputs decoded from the next state, so they align with c.
  always_comb begin
    state_d      = state_q;
    c_d          = c_q;
    num_steps_d  = num_steps_q;
    alpha_d      = alpha_q;
    step_count_d = step_count_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_steps_d  = num_steps;
          alpha_d      = alpha_delta;
          step_count_d = '0;
          c_d          = '0;
          state_d      = (num_steps == '0) ? S_DONE : S_SWEEP;
        end
      end
      S_SWEEP: begin
        if (c_q == LAST_C) begin
          c_d     = FLUSH_C;
          state_d = S_FLUSH;
        end else begin
          c_d = c_q + CW'(1);
        end
      end
      S_FLUSH: begin
        step_count_d = step_count_q + SW'(1);
        c_d          = '0;
        state_d      = (step_count_d == num_steps_q) ? S_DONE : S_SWEEP;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_SWEEP) || (state_d == S_FLUSH);
    done_d = (state_d == S_DONE);

    // Address holds through FLUSH so a 256-row column never aliases back to row 0 early.
    rd_addr_d = '0;
    if (state_d == S_SWEEP)      rd_addr_d = AW'(c_d);
    else if (state_d == S_FLUSH) rd_addr_d = rd_addr_q;

    // Interior row c-2 is written in cycles 3..ROWS; boundary rows are never touched.
    we_d      = busy_d && (c_d >= FIRST_WR) && (c_d <= FLUSH_C);
    wr_addr_d = we_d ? AW'(c_d - CW'(2)) : wr_addr_q;

    node_center_d = q_center;
    node_up_d     = node_center_q;
    node_left_d   = q_left;
    node_right_d  = q_right;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      c_q           <= '0;
      num_steps_q   <= '0;
      alpha_q       <= '0;
      step_count_q  <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      we_q          <= 1'b0;
      rd_addr_q     <= '0;
      wr_addr_q     <= '0;
      node_center_q <= '0;
      node_up_q     <= '0;
      node_left_q   <= '0;
      node_right_q  <= '0;
    end else begin
      state_q       <= state_d;
      c_q           <= c_d;
      num_steps_q   <= num_steps_d;
      alpha_q       <= alpha_d;
      step_count_q  <= step_count_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      we_q          <= we_d;
      rd_addr_q     <= rd_addr_d;
      wr_addr_q     <= wr_addr_d;
      node_center_q <= node_center_d;
      node_up_q     <= node_up_d;
      node_left_q   <= node_left_d;
      node_right_q  <= node_right_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign step_count       = step_count_q;
  assign rd_addr          = rd_addr_q;
  assign wr_addr          = wr_addr_q;
  assign we               = we_q;
  assign wr_data          = new_center;
  assign node_up          = node_up_q;
  assign node_center      = node_center_q;
  assign node_down        = q_center;
  assign node_left        = node_left_q;
  assign node_right       = node_right_q;
  assign mult_alpha_delta = alpha_q;

endmodule

// File: tb/tb_heat_column_sweep_ctrl.sv
// Directed bench for heat_column_sweep_ctrl: three column instances (ROWS 4, 8, 256) with
// M10K-style memories and a 5.27 stencil model standing in for the compute block.
module tb_heat_column_sweep_ctrl;

  localparam logic [31:0] ONE     = 32'h0800_0000;
  localparam logic [31:0] QUARTER = 32'h0200_0000;
  localparam logic [31:0] HALF    = 32'h0400_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  start_v;
  logic [2:0]  rstn_v;
  logic [2:0]  load_v;
  logic [15:0] num_steps;
  logic [31:0] alpha;
  logic [31:0] pat_c [256];
  logic [31:0] pat_l [256];
  logic [31:0] pat_r [256];

  logic        busy_v [3];
  logic        done_v [3];
  logic        we_v   [3];
  logic [15:0] sc_v   [3];
  logic [7:0]  ra_v   [3];
  logic [7:0]  wa_v   [3];
  logic [31:0] wd_v   [3];
  logic [31:0] ma_v   [3];

  int unsigned n_cmp;
  int unsigned n_bad;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned R = (g == 0) ? 4 : ((g == 1) ? 8 : 256);
    logic        busy, done, we;
    logic [15:0] step_count;
    logic [7:0]  rd_addr, wr_addr;
    logic [31:0] q_center, q_left, q_right, wr_data;
    logic [31:0] node_up, node_center, node_down, node_left, node_right;
    logic [31:0] mult_alpha_delta, new_center;
    logic [31:0] mem [256];
    logic signed [63:0] lap, prod;

    heat_column_sweep_ctrl #(.ROWS(R), .AW(8), .DW(32)) u_dut (
      .clk              (clk),
      .reset_n          (rstn_v[g]),
      .start            (start_v[g]),
      .num_steps        (num_steps),
      .alpha_delta      (alpha),
      .busy             (busy),
      .done             (done),
      .step_count       (step_count),
      .rd_addr          (rd_addr),
      .q_center         (q_center),
      .q_left           (q_left),
      .q_right          (q_right),
      .wr_addr          (wr_addr),
      .we               (we),
      .wr_data          (wr_data),
      .node_up          (node_up),
      .node_center      (node_center),
      .node_down        (node_down),
      .node_left        (node_left),
      .node_right       (node_right),
      .mult_alpha_delta (mult_alpha_delta),
      .new_center       (new_center)
    );

    // Column memory with 1-cycle registered read; neighbour columns are read-only patterns.
    always @(posedge clk) begin
      if (load_v[g]) begin
        for (int i = 0; i < 256; i++) mem[i] <= pat_c[i];
      end else if (we) begin
        mem[wr_addr] <= wr_data;
      end
      q_center <= mem[rd_addr];
      q_left   <= pat_l[rd_addr];
      q_right  <= pat_r[rd_addr];
    end

    // center + alpha*(up+down+left+right-4*center) in 5.27
    always_comb begin
      lap = 64'($signed(node_up)) + 64'($signed(node_down)) + 64'($signed(node_left))
          + 64'($signed(node_right)) - 64'sd4 * 64'($signed(node_center));
      prod = lap * 64'($signed(mult_alpha_delta));
      new_center = node_center + 32'(prod >>> 27);
    end

    assign busy_v[g] = busy;
    assign done_v[g] = done;
    assign we_v[g]   = we;
    assign sc_v[g]   = step_count;
    assign ra_v[g]   = rd_addr;
    assign wa_v[g]   = wr_addr;
    assign wd_v[g]   = wr_data;
    assign ma_v[g]   = mult_alpha_delta;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic load_col(input int g);
    @(negedge clk);
    load_v[g] = 1'b1;
    @(negedge clk);
    load_v[g] = 1'b0;
  endtask

  // Returns in the middle of cycle 0 (first busy cycle, or DONE when num_steps is 0).
  task automatic pulse_start(input int g);
    @(negedge clk);
    start_v[g] = 1'b1;
    @(negedge clk);
    start_v[g] = 1'b0;
  endtask

  initial begin
    int unsigned last_wa;
    int unsigned n_we;
    n_cmp = 0;
    n_bad = 0;
    start_v = '0;
    load_v = '0;
    rstn_v = '0;
    num_steps = '0;
    alpha = '0;
    for (int i = 0; i < 256; i++) begin
      pat_c[i] = '0;
      pat_l[i] = '0;
      pat_r[i] = '0;
    end

    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("rst_busy", 32'(busy_v[g]), 32'd0);
      chk("rst_done", 32'(done_v[g]), 32'd0);
      chk("rst_we", 32'(we_v[g]), 32'd0);
      chk("rst_step", 32'(sc_v[g]), 32'd0);
      chk("rst_rd", 32'(ra_v[g]), 32'd0);
      chk("rst_wa", 32'(wa_v[g]), 32'd0);
      chk("rst_alpha", ma_v[g], 32'd0);
    end
    rstn_v = 3'b111;

    // ROWS=4: single spike, one step
    pat_c[1] = ONE;
    load_col(0);
    num_steps = 16'd1;
    alpha = QUARTER;
    pulse_start(0);
    for (int k = 0; k <= 5; k++) begin
      chk("t1_busy", 32'(busy_v[0]), 32'(k < 5));
      chk("t1_done", 32'(done_v[0]), 32'(k == 5));
      chk("t1_we", 32'(we_v[0]), 32'(k == 3 || k == 4));
      if (k < 4) chk("t1_rd", 32'(ra_v[0]), 32'(k));
      if (k == 0) chk("t1_alpha", ma_v[0], QUARTER);
      if (k == 3) begin
        chk("t1_wa3", 32'(wa_v[0]), 32'd1);
        chk("t1_wd3", wd_v[0], 32'h0);
      end
      if (k == 4) begin
        chk("t1_wa4", 32'(wa_v[0]), 32'd2);
        chk("t1_wd4", wd_v[0], QUARTER);
      end
      @(negedge clk);
    end
    chk("t1_mem0", g_dut[0].mem[0], 32'h0);
    chk("t1_mem1", g_dut[0].mem[1], 32'h0);
    chk("t1_mem2", g_dut[0].mem[2], QUARTER);
    chk("t1_mem3", g_dut[0].mem[3], 32'h0);
    chk("t1_step", 32'(sc_v[0]), 32'd1);

    // num_steps=0 goes straight to DONE
    num_steps = 16'd0;
    pulse_start(0);
    for (int k = 0; k <= 3; k++) begin
      chk("t2_done", 32'(done_v[0]), 32'(k == 0));
      chk("t2_busy", 32'(busy_v[0]), 32'd0);
      chk("t2_we", 32'(we_v[0]), 32'd0);
      chk("t2_rd", 32'(ra_v[0]), 32'd0);
      @(negedge clk);
    end

    // ROWS=8 uniform field, 3 steps, stray start mid-run
    for (int i = 0; i < 256; i++) begin
      pat_c[i] = ONE;
      pat_l[i] = ONE;
      pat_r[i] = ONE;
    end
    load_col(1);
    num_steps = 16'd3;
    alpha = QUARTER;
    pulse_start(1);
    for (int k = 0; k <= 27; k++) begin
      chk("t3_done", 32'(done_v[1]), 32'(k == 27));
      chk("t3_busy", 32'(busy_v[1]), 32'(k < 27));
      chk("t3_step", 32'(sc_v[1]), 32'(k / 9));
      chk("t3_we", 32'(we_v[1]), 32'(k < 27 && (k % 9) >= 3));
      if (k < 27 && (k % 9) < 8) chk("t3_rd", 32'(ra_v[1]), 32'(k % 9));
      if (we_v[1]) begin
        chk("t3_wd", wd_v[1], ONE);
        chk("t3_wa", 32'(wa_v[1]), 32'((k % 9) - 2));
      end
      start_v[1] = (k == 4);
      @(negedge clk);
    end
    start_v[1] = 1'b0;
    chk("t3_idle_busy", 32'(busy_v[1]), 32'd0);

    // ROWS=8 reset mid-pass: rows 1,2 written, rows >= 3 must be untouched
    for (int i = 0; i < 256; i++) pat_c[i] = '0;
    load_col(1);
    pulse_start(1);
    for (int k = 0; k < 4; k++) begin
      chk("t5_we_pre", 32'(we_v[1]), 32'(k == 3));
      @(negedge clk);
    end
    chk("t5_we4", 32'(we_v[1]), 32'd1);
    chk("t5_wa4", 32'(wa_v[1]), 32'd2);
    rstn_v[1] = 1'b0;
    @(negedge clk);
    chk("t5_we_rst", 32'(we_v[1]), 32'd0);
    chk("t5_busy_rst", 32'(busy_v[1]), 32'd0);
    chk("t5_step_rst", 32'(sc_v[1]), 32'd0);
    chk("t5_rd_rst", 32'(ra_v[1]), 32'd0);
    repeat (2) @(negedge clk);
    chk("t5_we_hold", 32'(we_v[1]), 32'd0);
    rstn_v[1] = 1'b1;
    @(negedge clk);
    chk("t5_we_post", 32'(we_v[1]), 32'd0);
    chk("t5_mem1", g_dut[1].mem[1], HALF);
    chk("t5_mem2", g_dut[1].mem[2], HALF);
    for (int i = 3; i < 8; i++) chk("t5_mem_hi", g_dut[1].mem[i], 32'h0);

    // ROWS=256, 2 steps: address wrap and last interior row
    for (int i = 0; i < 256; i++) begin
      pat_l[i] = '0;
      pat_r[i] = '0;
    end
    load_col(2);
    num_steps = 16'd2;
    last_wa = 0;
    n_we = 0;
    pulse_start(2);
    for (int k = 0; k <= 514; k++) begin
      if (k == 0 || k == 1 || k == 255 || k == 257 || k == 258 || k == 512)
        chk("t6_rd", 32'(ra_v[2]), 32'(k % 257));
      if (k == 256 || k == 257 || k == 513) chk("t6_busy", 32'(busy_v[2]), 32'd1);
      if (k >= 513) chk("t6_done", 32'(done_v[2]), 32'(k == 514));
      if (we_v[2]) begin
        n_we++;
        last_wa = 32'(wa_v[2]);
        if (wa_v[2] == 8'd0 || wa_v[2] == 8'd255) chk("t6_boundary_wr", 32'(wa_v[2]), 32'd1);
      end
      @(negedge clk);
    end
    chk("t6_last_wa", last_wa, 32'd254);
    chk("t6_n_we", n_we, 32'd508);
    chk("t6_step", 32'(sc_v[2]), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
